adder_stream_ctrl: RTL and testbench
====================================

// Module: adder_stream_ctrl
// PURPOSE
// Flow controller sequencing the four-channel beam-sum adder. Joins the S00/S01/S20/S21 input
// streams in lockstep and strobes the adder only when all channels hold valid data and the output
// slot is free. Applies beam-weight updates only at frame boundaries, and flags tlast
// misalignment and channel stalls. Sits between the RF-data DMA streams and axi_adder.
// PARAMETERS
// NUM_CH        4   joined input channels
// WEIGHT_WIDTH  8   width of each real/imag weight
// FRAME_CNT_W   16  frame counter width
// TIMEOUT_W     12  partial-valid stall counter width
// PORTS
// clock          in   1                     sole clock, rising edge
// resetn         in   1                     reset, asynchronous assert, active-low
// enable         in   1                     run request
// s_tvalid       in   NUM_CH                per-channel data valid
// s_tlast        in   NUM_CH                per-channel end of frame
// s_tready       out  NUM_CH                per-channel accept
// add_en         out  1                     adder capture strobe (= join fire)
// m_tvalid       out  1                     sum valid to downstream
// m_tlast        out  1                     sum end of frame
// m_tready       in   1                     downstream accept
// cfg_weights    in   NUM_CH*2*WEIGHT_WIDTH pending weights {ch3 im,re ... ch0 im,re}
// cfg_update     in   1                     pulse: latch cfg_weights as pending
// weights_active out  NUM_CH*2*WEIGHT_WIDTH weights driven to the adder
// frame_count    out  FRAME_CNT_W           completed frames, wraps
// err_misalign   out  1                     sticky: s_tlast bits unequal on fire
// err_timeout    out  1                     sticky: partial valid held too long
// err_clear      in   1                     pulse: clear errors, leave ERROR
// BEHAVIOUR
// - Reset values: all outputs 0; state IDLE; pending-update flag 0.
// - States: IDLE, RUN, STOPPING, ERROR.
//   IDLE->RUN on enable. RUN->STOPPING on !enable with beat_cnt!=0.
//   RUN->IDLE on !enable with beat_cnt==0. STOPPING->IDLE on a fire with tlast.
//   Any state except IDLE -> ERROR on an error event. ERROR->IDLE on err_clear.
// - can_accept = !m_tvalid | m_tready.
//   fire = (state RUN|STOPPING) & (&s_tvalid) & can_accept.
// - s_tready[i] = fire for all i, combinational. Ready depends on valid; valid never on ready.
// - add_en = fire. m_tvalid sets the cycle after fire (latency 1, matches registered adder
//   output). m_tvalid holds until m_tready. m_tlast is s_tlast[0] registered on fire.
// - Back-to-back fire is allowed when m_tready=1 (one beat/cycle). m_tvalid/m_tlast stay
//   stable while stalled.
// - beat_cnt increments on fire and clears on fire with tlast.
//   frame_count increments on fire with s_tlast[0]; wraps 2^FRAME_CNT_W-1 -> 0.
// - Misalign: fire with s_tlast not all-equal sets err_misalign and enters ERROR. The beat is
//   still consumed and emitted.
// - Timeout: stall_cnt counts cycles with s_tvalid nonzero and not all-ones in RUN/STOPPING.
//   It clears otherwise. Reaching 2^TIMEOUT_W-1 sets err_timeout and enters ERROR.
// - ERROR: no fire; the output register still drains via m_tready. err_clear clears both flags,
//   beat_cnt and stall_cnt. A simultaneous new error wins: stay in ERROR, flag set.
// - Weights: cfg_update latches cfg_weights into a pending register and sets the pending flag.
//   A later update overwrites the pending value. Pending transfers to weights_active:
//   - when beat_cnt==0 and no fire this cycle, in any state, or
//   - on the cycle of a tlast fire, so new weights take effect from the next beat.
//   cfg_update coinciding with a transfer: the new value is pending, the old one is applied.
// - Reset mid-frame: immediate return to reset values. Partial frame is discarded; the upstream
//   re-aligns.
// STRUCTURE
// - Shared package (beam_pkg): NUM_CH, WEIGHT_WIDTH, the state enum, and the weight-vector
//   slice helpers.
// - One sub-module: stream_join_ctrl, the fire/ready/output-register logic.
//   The top keeps the FSM, counters, weight shadowing and error logic.
// TESTING
// - All four valid, m_tready=1, 8-beat frame with tlast on beat 8 -> 8 add_en pulses,
//   m_tvalid 1 cycle late, m_tlast on 8th output, frame_count=1.
// - s_tvalid=4'b1011 for 4095 cycles -> no s_tready; err_timeout=1, ERROR.
//   err_clear -> IDLE, flag 0.
// - Fire with s_tlast=4'b0111 -> beat emitted, err_misalign=1, no further fire until err_clear.
// - cfg_update at beat 3 of 8 -> weights_active unchanged through beat 8, new value on the cycle
//   after the tlast fire.
// - m_tready low 5 cycles mid-frame -> m_tvalid held, one fire max; the stalled output is stable.
// - enable dropped at beat 2 -> STOPPING, frame completes, IDLE. Async resetn low mid-frame ->
//   all outputs 0 immediately.

Source files
------------

// File: rtl/beam_pkg.sv
// Shared constants, FSM state type and weight-vector helpers for the beam-sum adder controller.
package beam_pkg;

    localparam int NUM_CH       = 4;
    localparam int WEIGHT_WIDTH = 8;
    localparam int FRAME_CNT_W  = 16;
    localparam int TIMEOUT_W    = 12;
    localparam int WEIGHTS_W    = NUM_CH * 2 * WEIGHT_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2,
        ST_ERROR    = 2'd3
    } state_t;

    // Weight vector layout per channel is {im, re}, channel 0 in the low bits.
    function automatic logic [WEIGHT_WIDTH-1:0] weight_re(input logic [WEIGHTS_W-1:0] w,
                                                          input int unsigned ch);
        return w[ch*2*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    endfunction

    function automatic logic [WEIGHT_WIDTH-1:0] weight_im(input logic [WEIGHTS_W-1:0] w,
                                                          input int unsigned ch);
        return w[ch*2*WEIGHT_WIDTH + WEIGHT_WIDTH +: WEIGHT_WIDTH];
    endfunction

endpackage

// File: rtl/stream_join_ctrl.sv
// Lockstep join of the input channels into one adder strobe, plus the one-deep output
// valid/last register that mirrors the adder's registered sum.
module stream_join_ctrl #(
    parameter int NUM_CH = beam_pkg::NUM_CH
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              run,
    input  logic [NUM_CH-1:0] s_tvalid,
    input  logic              beat_last,
    input  logic              m_tready,
    output logic [NUM_CH-1:0] s_tready,
    output logic              fire,
    output logic              m_tvalid,
    output logic              m_tlast
);

    logic can_accept;

    // NOTE: every signal written here is assigned on every path, so no latch can be inferred.
    always_comb begin
        can_accept = !m_tvalid || m_tready;
        fire       = run && (&s_tvalid) && can_accept;
        s_tready   = {NUM_CH{fire}};
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
        end else if (fire) begin
            m_tvalid <= 1'b1;
            m_tlast  <= beat_last;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
        end
    end

endmodule

// File: rtl/adder_stream_ctrl.sv
// Flow controller for the four-channel beam-sum adder: FSM, frame/beat counters,
// frame-aligned weight shadowing and sticky misalign/stall error detection.
module adder_stream_ctrl
    import beam_pkg::*;
#(
    parameter int NUM_CH       = beam_pkg::NUM_CH,
    parameter int WEIGHT_WIDTH = beam_pkg::WEIGHT_WIDTH,
    parameter int FRAME_CNT_W  = beam_pkg::FRAME_CNT_W,
    parameter int TIMEOUT_W    = beam_pkg::TIMEOUT_W
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           enable,
    input  logic [NUM_CH-1:0]              s_tvalid,
    input  logic [NUM_CH-1:0]              s_tlast,
    output logic [NUM_CH-1:0]              s_tready,
    output logic                           add_en,
    output logic                           m_tvalid,
    output logic                           m_tlast,
    input  logic                           m_tready,
    input  logic [NUM_CH*2*WEIGHT_WIDTH-1:0] cfg_weights,
    input  logic                           cfg_update,
    output logic [NUM_CH*2*WEIGHT_WIDTH-1:0] weights_active,
    output logic [FRAME_CNT_W-1:0]         frame_count,
    output logic                           err_misalign,
    output logic                           err_timeout,
    input  logic                           err_clear
);

    localparam int WV_W   = NUM_CH * 2 * WEIGHT_WIDTH;
    localparam int BEAT_W = 16;
    localparam logic [TIMEOUT_W-1:0] STALL_LIMIT = {TIMEOUT_W{1'b1}};

    state_t            state;
    logic              run;
    logic              fire;
    logic              tlast_fire;
    logic              misalign_evt;
    logic              partial;
    logic              timeout_evt;
    logic              err_evt;
    logic              transfer;
    logic [BEAT_W-1:0] beat_cnt;
    logic [BEAT_W-1:0] beat_next;
    logic [TIMEOUT_W-1:0] stall_cnt;
    logic [WV_W-1:0]   pend_weights;
    logic              pend_valid;

    stream_join_ctrl #(.NUM_CH(NUM_CH)) u_join (
        .clock     (clock),
        .resetn    (resetn),
        .run       (run),
        .s_tvalid  (s_tvalid),
        .beat_last (s_tlast[0]),
        .m_tready  (m_tready),
        .s_tready  (s_tready),
        .fire      (fire),
        .m_tvalid  (m_tvalid),
        .m_tlast   (m_tlast)
    );

    assign add_en = fire;

    always_comb begin
        run          = (state == ST_RUN) || (state == ST_STOPPING);
        tlast_fire   = fire && s_tlast[0];
        misalign_evt = fire && !((&s_tlast) || !(|s_tlast));
        partial      = run && (|s_tvalid) && !(&s_tvalid);
        timeout_evt  = partial && (stall_cnt == STALL_LIMIT - 1'b1);
        err_evt      = misalign_evt || timeout_evt;
        beat_next    = beat_cnt;
        if (fire)
            beat_next = tlast_fire ? '0 : beat_cnt + 1'b1;
        // Weights swap only between frames: idle at a boundary, or on the closing beat itself.
        transfer     = pend_valid && (((beat_cnt == '0) && !fire) || tlast_fire);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state          <= ST_IDLE;
            beat_cnt       <= '0;
            stall_cnt      <= '0;
            frame_count    <= '0;
            err_misalign   <= 1'b0;
            err_timeout    <= 1'b0;
            // NOTE: the pending weight register is reset as well; it is a single register, not a memory.
            pend_weights   <= '0;
            pend_valid     <= 1'b0;
            weights_active <= '0;
        end else begin
            beat_cnt  <= beat_next;
            stall_cnt <= partial ? stall_cnt + 1'b1 : '0;
            if (tlast_fire)
                frame_count <= frame_count + 1'b1;

            // A new error in the same cycle as err_clear keeps its flag set.
            if (err_clear) begin
                err_misalign <= 1'b0;
                err_timeout  <= 1'b0;
            end
            if (misalign_evt)
                err_misalign <= 1'b1;
            if (timeout_evt)
                err_timeout <= 1'b1;

            if (transfer) begin
                weights_active <= pend_weights;
                pend_valid     <= 1'b0;
            end
            if (cfg_update) begin
                pend_weights <= cfg_weights;
                pend_valid   <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (enable)
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    if (err_evt)
                        state <= ST_ERROR;
                    else if (!enable)
                        state <= (beat_next == '0) ? ST_IDLE : ST_STOPPING;
                end
                ST_STOPPING: begin
                    if (err_evt)
                        state <= ST_ERROR;
                    else if (tlast_fire)
                        state <= ST_IDLE;
                end
                ST_ERROR: begin
                    if (err_clear && !err_evt) begin
                        state     <= ST_IDLE;
                        beat_cnt  <= '0;
                        stall_cnt <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_stream_ctrl.sv
// Scoreboard bench for adder_stream_ctrl: the driver queues each accepted beat's expected
// m_tlast, an independent monitor pops on every output handshake; directed checks cover the rest.
module tb_adder_stream_ctrl;
    import beam_pkg::*;

    logic                 clock = 1'b0;
    logic                 resetn;
    logic                 enable;
    logic [NUM_CH-1:0]    s_tvalid;
    logic [NUM_CH-1:0]    s_tlast;
    logic [NUM_CH-1:0]    s_tready;
    logic                 add_en;
    logic                 m_tvalid;
    logic                 m_tlast;
    logic                 m_tready;
    logic [WEIGHTS_W-1:0] cfg_weights;
    logic                 cfg_update;
    logic [WEIGHTS_W-1:0] weights_active;
    logic [FRAME_CNT_W-1:0] frame_count;
    logic                 err_misalign;
    logic                 err_timeout;
    logic                 err_clear;

    localparam logic [WEIGHTS_W-1:0] W0 = 64'h0807_0605_0403_0201;
    localparam logic [WEIGHTS_W-1:0] W1 = 64'hF0E1_D2C3_B4A5_9687;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_add    = 0;
    logic exp_q[$];

    adder_stream_ctrl dut (
        .clock          (clock),
        .resetn         (resetn),
        .enable         (enable),
        .s_tvalid       (s_tvalid),
        .s_tlast        (s_tlast),
        .s_tready       (s_tready),
        .add_en         (add_en),
        .m_tvalid       (m_tvalid),
        .m_tlast        (m_tlast),
        .m_tready       (m_tready),
        .cfg_weights    (cfg_weights),
        .cfg_update     (cfg_update),
        .weights_active (weights_active),
        .frame_count    (frame_count),
        .err_misalign   (err_misalign),
        .err_timeout    (err_timeout),
        .err_clear      (err_clear)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Presents one lockstep beat and waits (bounded) for the join to take it.
    task automatic send_beat(input logic [NUM_CH-1:0] last);
        int   waited = 0;
        logic got    = 1'b0;
        s_tvalid = '1;
        s_tlast  = last;
        while (!got && waited < 20) begin
            @(negedge clock);
            if (s_tready == '1)
                got = 1'b1;
            else
                waited++;
        end
        check("beat_accepted", got, 1);
        if (got)
            exp_q.push_back(last[0]);
        @(posedge clock);
        #1;
        s_tvalid = '0;
        s_tlast  = '0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Output monitor: one expected beat per downstream handshake.
    initial begin
        logic exp_last;
        forever begin
            @(negedge clock);
            if (resetn && m_tvalid && m_tready) begin
                check("out_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_last = exp_q.pop_front();
                    check("m_tlast_beat", m_tlast, exp_last);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (resetn && add_en)
                n_add++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int bad;

        resetn      = 1'b0;
        enable      = 1'b0;
        s_tvalid    = '0;
        s_tlast     = '0;
        m_tready    = 1'b0;
        cfg_weights = '0;
        cfg_update  = 1'b0;
        err_clear   = 1'b0;

        repeat (2) @(negedge clock);
        check("rst_s_tready", s_tready, 0);
        check("rst_add_en", add_en, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_weights", weights_active, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_err_misalign", err_misalign, 0);
        check("rst_err_timeout", err_timeout, 0);

        // Frame 1: eight beats at full rate.
        next_cycle();
        resetn   = 1'b1;
        enable   = 1'b1;
        m_tready = 1'b1;
        @(negedge clock);
        check("pre_fire_m_tvalid", m_tvalid, 0);
        base = n_add;
        send_beat(4'h0);
        check("first_out_latency", m_tvalid, 1);
        repeat (6) send_beat(4'h0);
        send_beat(4'hF);
        repeat (2) @(negedge clock);
        check("f1_add_en_pulses", n_add - base, 8);
        check("f1_frame_count", frame_count, 1);
        check("f1_queue_drained", exp_q.size(), 0);

        // Idle-boundary weight update: pending one cycle, active the next.
        next_cycle();
        cfg_weights = W0;
        cfg_update  = 1'b1;
        next_cycle();
        cfg_update  = 1'b0;
        cfg_weights = '0;
        check("w0_pending_only", weights_active, 0);
        next_cycle();
        check("w0_applied_idle", weights_active, W0);

        // Frame 2: update at beat 3, downstream stall mid-frame.
        send_beat(4'h0);
        send_beat(4'h0);
        cfg_weights = W1;
        cfg_update  = 1'b1;
        next_cycle();
        cfg_update  = 1'b0;
        cfg_weights = '0;
        send_beat(4'h0);
        check("w_hold_beat3", weights_active, W0);

        m_tready = 1'b0;
        s_tvalid = '1;
        s_tlast  = '0;
        base     = n_add;
        bad      = 0;
        repeat (5) begin
            @(negedge clock);
            if (m_tvalid !== 1'b1 || m_tlast !== 1'b0 || s_tready !== '0)
                bad++;
        end
        check("stall_output_stable", bad, 0);
        check("stall_no_fire", n_add - base, 0);
        next_cycle();
        m_tready = 1'b1;
        s_tvalid = '0;

        repeat (4) send_beat(4'h0);
        check("w_hold_beat7", weights_active, W0);
        send_beat(4'hF);
        check("w_applied_after_tlast", weights_active, W1);
        check("w_ch2_re", weight_re(weights_active, 2), 8'hC3);
        check("w_ch2_im", weight_im(weights_active, 2), 8'hD2);
        repeat (2) @(negedge clock);
        check("f2_frame_count", frame_count, 2);
        check("f2_queue_drained", exp_q.size(), 0);

        // Frame 3: enable dropped at beat 2, frame still completes, then idle.
        next_cycle();
        send_beat(4'h0);
        send_beat(4'h0);
        enable = 1'b0;
        repeat (3) send_beat(4'h0);
        send_beat(4'hF);
        s_tvalid = '1;
        bad      = 0;
        repeat (3) begin
            @(negedge clock);
            if (s_tready !== '0)
                bad++;
        end
        check("stopped_no_ready", bad, 0);
        next_cycle();
        s_tvalid = '0;
        check("f3_frame_count", frame_count, 3);

        // Misaligned tlast: beat consumed and emitted, then no fire until cleared.
        enable = 1'b1;
        send_beat(4'b0111);
        check("misalign_flag", err_misalign, 1);
        s_tvalid = '1;
        bad      = 0;
        repeat (4) begin
            @(negedge clock);
            if (s_tready !== '0)
                bad++;
        end
        check("error_no_ready", bad, 0);
        check("error_output_drained", m_tvalid, 0);
        check("misalign_frame_count", frame_count, 4);
        next_cycle();
        s_tvalid  = '0;
        enable    = 1'b0;
        err_clear = 1'b1;
        next_cycle();
        err_clear = 1'b0;
        check("misalign_cleared", err_misalign, 0);

        // Partial-valid stall: flag on the 4095th counted cycle, not before.
        enable = 1'b1;
        next_cycle();
        s_tvalid = 4'b1011;
        bad      = 0;
        repeat (4095) begin
            @(negedge clock);
            if (s_tready !== '0)
                bad++;
        end
        check("timeout_not_yet", err_timeout, 0);
        @(negedge clock);
        check("timeout_flag", err_timeout, 1);
        check("timeout_no_ready", bad, 0);
        next_cycle();
        enable    = 1'b0;
        err_clear = 1'b1;
        next_cycle();
        err_clear = 1'b0;
        check("timeout_cleared", err_timeout, 0);
        repeat (3) next_cycle();
        check("timeout_stays_clear_idle", err_timeout, 0);
        s_tvalid = '0;

        // Asynchronous reset in the middle of a frame with a held output.
        enable = 1'b1;
        send_beat(4'h0);
        send_beat(4'h0);
        m_tready = 1'b0;
        @(negedge clock);
        check("pre_rst_m_tvalid", m_tvalid, 1);
        check("pre_rst_frame_count", frame_count, 4);
        #2;
        exp_q.delete();
        resetn = 1'b0;
        #1;
        check("async_rst_m_tvalid", m_tvalid, 0);
        check("async_rst_frame_count", frame_count, 0);
        check("async_rst_weights", weights_active, 0);
        check("async_rst_s_tready", s_tready, 0);
        next_cycle();
        resetn = 1'b1;
        enable = 1'b0;
        repeat (2) next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
